// File: rtl/tlb_refill_walker_pkg.sv
// Shared definitions for the TLB refill walker.
// State encoding, PTE field positions and TLB geometry.
package tlb_refill_walker_pkg;

    localparam int TLB_ENTRIES = 16;

    localparam int PTE_G      = 0;
    localparam int PTE_V      = 1;
    localparam int PTE_D      = 2;
    localparam int PTE_C_LO   = 3;
    localparam int PTE_C_HI   = 5;
    localparam int PTE_PFN_LO = 6;
    localparam int PTE_PFN_HI = 29;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_EVEN = 3'd1,
        ST_RD_ODD  = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FAULT   = 3'd4
    } walk_state_e;

    function automatic logic pte_valid(input logic [31:0] pte);
        return pte[PTE_V];
    endfunction

endpackage

// File: rtl/tlb_random_ctr.sv
// Random register: free-running down counter over [wired, max].
// Shared with CP0, which reads it as the Random register.
module tlb_random_ctr
    import tlb_refill_walker_pkg::*;
#(
    parameter int IDX_W = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] wired,
    output logic [IDX_W-1:0] rnd
);

    localparam logic [IDX_W-1:0] RND_MAX = '1;

    logic [IDX_W-1:0] rnd_q;
    logic [IDX_W-1:0] rnd_d;

    // Reload at wired, or at zero when wired was raised above the count.
    always_comb begin
        rnd_d = rnd_q - 1'b1;
        if (rnd_q == wired || rnd_q == '0) begin
            rnd_d = RND_MAX;
        end
    end

    // Counter register; comes out of reset at the top entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rnd_q <= RND_MAX;
        end else begin
            rnd_q <= rnd_d;
        end
    end

    assign rnd = rnd_q;

endmodule

// File: rtl/tlb_refill_walker.sv
// Hardware TLB refill: reads the even/odd PTE pair on a miss
// and writes it to a random slot, or reports a refill fault.
module tlb_refill_walker
    import tlb_refill_walker_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_req,
    input  logic [31:0]      miss_vaddr,
    input  logic [7:0]       asid,
    input  logic [31:0]      pte_base,
    input  logic [IDX_W-1:0] wired,
    input  logic             abort,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             tlb_we,
    output logic [31:0]      tlb_index,
    output logic [31:0]      tlb_entry_hi,
    output logic [31:0]      tlb_entry_lo0,
    output logic [31:0]      tlb_entry_lo1,
    output logic             refill_done,
    output logic             refill_fault,
    output logic             busy,
    output logic [IDX_W-1:0] random_out
);

    walk_state_e state_q, state_d;
    logic [18:0] vpn2_q, vpn2_d;
    logic [7:0]  asid_q, asid_d;
    logic [31:0] lo0_q, lo0_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] elo0_q, elo0_d;
    logic [31:0] elo1_q, elo1_d;
    logic [IDX_W-1:0] rnd;

    // The page offset below the even/odd pair is not needed.
    logic unused_vaddr_lo;
    assign unused_vaddr_lo = ^miss_vaddr[12:0];

    tlb_random_ctr #(.IDX_W(IDX_W)) u_random (
        .clk   (clk),
        .rst   (rst),
        .wired (wired),
        .rnd   (rnd)
    );

    // Walk sequencing; abort freezes captures and returns to idle.
    always_comb begin
        state_d    = state_q;
        vpn2_d     = vpn2_q;
        asid_d     = asid_q;
        lo0_d      = lo0_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        hi_d       = hi_q;
        elo0_d     = elo0_q;
        elo1_d     = elo1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (miss_req) begin
                    state_d    = ST_RD_EVEN;
                    vpn2_d     = miss_vaddr[31:13];
                    asid_d     = asid;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pte_base
                               + {10'b0, miss_vaddr[31:13], 3'b000};
                end
            end
            ST_RD_EVEN: begin
                if (mem_ack) begin
                    state_d    = ST_RD_ODD;
                    lo0_d      = mem_rdata;
                    mem_addr_d = mem_addr_q + 32'd4;
                end
            end
            ST_RD_ODD: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (pte_valid(lo0_q) || pte_valid(mem_rdata)) begin
                        state_d = ST_WRITE;
                        hi_d    = {vpn2_q, 5'b0, asid_q};
                        elo0_d  = lo0_q;
                        elo1_d  = mem_rdata;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            vpn2_d     = vpn2_q;
            asid_d     = asid_q;
            lo0_d      = lo0_q;
            mem_req_d  = 1'b0;
            mem_addr_d = mem_addr_q;
            hi_d       = hi_q;
            elo0_d     = elo0_q;
            elo1_d     = elo1_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            vpn2_q     <= '0;
            asid_q     <= '0;
            lo0_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            hi_q       <= '0;
            elo0_q     <= '0;
            elo1_q     <= '0;
        end else begin
            state_q    <= state_d;
            vpn2_q     <= vpn2_d;
            asid_q     <= asid_d;
            lo0_q      <= lo0_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            hi_q       <= hi_d;
            elo0_q     <= elo0_d;
            elo1_q     <= elo1_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign tlb_we        = (state_q == ST_WRITE) && !abort;
    assign refill_done   = (state_q == ST_WRITE) && !abort;
    assign refill_fault  = (state_q == ST_FAULT) && !abort;
    assign busy          = (state_q != ST_IDLE);
    assign tlb_index     = {{(32-IDX_W){1'b0}}, rnd};
    assign tlb_entry_hi  = hi_q;
    assign tlb_entry_lo0 = elo0_q;
    assign tlb_entry_lo1 = elo1_q;
    assign random_out    = rnd;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Scoreboard bench for tlb_refill_walker: random misses against
// a memory responder, a Random model and directed corner cases.
module tb_tlb_refill_walker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_req;
    logic [31:0] miss_vaddr;
    logic [7:0]  asid;
    logic [31:0] pte_base;
    logic [3:0]  wired;
    logic        abort;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        tlb_we;
    logic [31:0] tlb_index;
    logic [31:0] tlb_entry_hi;
    logic [31:0] tlb_entry_lo0;
    logic [31:0] tlb_entry_lo1;
    logic        refill_done;
    logic        refill_fault;
    logic        busy;
    logic [3:0]  random_out;

    always #5 clk = ~clk;

    tlb_refill_walker #(.IDX_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .miss_req      (miss_req),
        .miss_vaddr    (miss_vaddr),
        .asid          (asid),
        .pte_base      (pte_base),
        .wired         (wired),
        .abort         (abort),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .tlb_we        (tlb_we),
        .tlb_index     (tlb_index),
        .tlb_entry_hi  (tlb_entry_hi),
        .tlb_entry_lo0 (tlb_entry_lo0),
        .tlb_entry_lo1 (tlb_entry_lo1),
        .refill_done   (refill_done),
        .refill_fault  (refill_fault),
        .busy          (busy),
        .random_out    (random_out)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } rd_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
        logic        fault;
    } exp_t;

    rd_t  rd_q[$];
    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    logic        auto_mem;
    int          mem_delay;
    logic        r_ack, m_ack;
    logic [31:0] r_data, m_data;

    assign mem_ack   = auto_mem ? r_ack  : m_ack;
    assign mem_rdata = auto_mem ? r_data : m_data;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     name, act, exp);
        end
    endtask

    // Random register reference: count down, reload 15 at wired or 0.
    logic [3:0] mr;
    always @(posedge clk or negedge rst) begin
        if (!rst)
            mr <= 4'd15;
        else if (mr == wired || mr == 4'd0)
            mr <= 4'd15;
        else
            mr <= mr - 4'd1;
    end

    // Monitor: Random every cycle, pops the scoreboard on any pulse.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            chk("random_out", 32'(random_out), 32'(mr));
            if (tlb_we || refill_done || refill_fault) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse",
                        32'({tlb_we, refill_done, refill_fault}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.fault) begin
                        chk("fault_pulse",
                            32'({tlb_we, refill_done, refill_fault}),
                            32'b001);
                    end else begin
                        chk("write_pulse",
                            32'({tlb_we, refill_done, refill_fault}),
                            32'b110);
                        chk("entry_hi", tlb_entry_hi, e.hi);
                        chk("entry_lo0", tlb_entry_lo0, e.lo0);
                        chk("entry_lo1", tlb_entry_lo1, e.lo1);
                        chk("tlb_index", tlb_index, 32'(mr));
                    end
                end
            end
        end
    end

    // Memory responder: checks each requested address, acks after delay.
    initial begin : resp
        logic active;
        int   wcnt;
        rd_t  cur;
        active = 1'b0;
        wcnt   = 0;
        r_ack  = 1'b0;
        r_data = '0;
        forever begin
            @(negedge clk);
            r_ack  = 1'b0;
            r_data = $urandom;
            if (auto_mem && rst && mem_req) begin
                if (!active) begin
                    if (rd_q.size() == 0) begin
                        chk("unexpected_req", 32'(mem_req), 32'd0);
                    end else begin
                        cur    = rd_q.pop_front();
                        active = 1'b1;
                        wcnt   = 0;
                    end
                end
                if (active) begin
                    chk("mem_addr", mem_addr, cur.addr);
                    if (wcnt == mem_delay) begin
                        r_ack  = 1'b1;
                        r_data = cur.data;
                        active = 1'b0;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [31:0] va, input logic [31:0] base,
                         input logic [7:0] as, input logic [31:0] l0,
                         input logic [31:0] l1, input int d);
        logic [31:0] a;
        exp_t        e;
        int          cnt;
        wait_idle();
        a = base + ((va >> 13) << 3);
        rd_q.push_back('{a, l0});
        rd_q.push_back('{a + 32'd4, l1});
        e.hi    = (va & 32'hFFFF_E000) | {24'b0, as};
        e.lo0   = l0;
        e.lo1   = l1;
        e.fault = !(l0[1] || l1[1]);
        exp_q.push_back(e);
        mem_delay  = d;
        miss_req   = 1'b1;
        miss_vaddr = va;
        asid       = as;
        pte_base   = base;
        @(negedge clk);
        miss_req   = 1'b0;
        miss_vaddr = $urandom;
        asid       = 8'($urandom);
        pte_base   = $urandom;
        cnt = 1;
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("latency", cnt, 4 + 2 * d);
    endtask

    initial begin
        int seq12[4]  = '{15, 14, 13, 12};
        int seqhi[7]  = '{4, 3, 2, 1, 0, 15, 14};
        int n;
        logic [31:0] l0, l1;
        miss_req   = 1'b0;
        miss_vaddr = '0;
        asid       = '0;
        pte_base   = '0;
        wired      = 4'd0;
        abort      = 1'b0;
        auto_mem   = 1'b1;
        mem_delay  = 0;
        m_ack      = 1'b0;
        m_data     = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_we", 32'({tlb_we, refill_done, refill_fault}), 32'd0);
        chk("rst_hi", tlb_entry_hi, 32'd0);
        chk("rst_lo0", tlb_entry_lo0, 32'd0);
        chk("rst_lo1", tlb_entry_lo1, 32'd0);
        chk("rst_random", 32'(random_out), 32'd15);
        rst = 1'b1;

        issue(32'h0040_2000, 32'h8010_0000, 8'h05,
              32'h0000_1047, 32'h0000_1087, 0);
        issue(32'h1234_5678, 32'h8000_0000, 8'h33, 32'h0, 32'h0, 0);
        chk("hold_hi", tlb_entry_hi, 32'h0040_2005);
        chk("hold_lo0", tlb_entry_lo0, 32'h0000_1047);
        issue(32'hFFFF_E000, 32'h0010_0008, 8'hAA, 32'h2, 32'h0, 3);
        issue(32'h0000_6000, 32'hFFFF_FFF8, 8'h11, 32'h0, 32'h2, 1);

        wired = 4'd12;
        n = 0;
        while (random_out != 4'd12 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wired12_reach", 32'(random_out), 32'd12);
        foreach (seq12[i]) begin
            @(negedge clk);
            chk("wired12_seq", 32'(random_out), seq12[i]);
        end

        wired = 4'd0;
        n = 0;
        while (random_out != 4'd5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        wired = 4'd10;
        foreach (seqhi[i]) begin
            @(negedge clk);
            chk("wired_raised_seq", 32'(random_out), seqhi[i]);
        end

        wired = 4'd15;
        n = 0;
        while (random_out != 4'd15 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (8) begin
            @(negedge clk);
            chk("wired15_hold", 32'(random_out), 32'd15);
        end
        issue(32'h0ABC_D000, 32'h0000_1000, 8'h7E, 32'h6, 32'h6, 2);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) wired = 4'($urandom_range(0, 15));
            l0 = $urandom;
            l1 = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                l0[1] = 1'b0;
                l1[1] = 1'b0;
            end
            issue($urandom, $urandom & 32'hFFFF_FFF8, 8'($urandom),
                  l0, l1, $urandom_range(0, 3));
        end

        auto_mem = 1'b0;
        wait_idle();
        miss_req   = 1'b1;
        miss_vaddr = 32'h0000_4000;
        pte_base   = 32'h1000_0000;
        asid       = 8'h01;
        @(negedge clk);
        miss_req = 1'b0;
        chk("abort_req_even", 32'(mem_req), 32'd1);
        chk("abort_addr_even", mem_addr, 32'h1000_0010);
        m_ack  = 1'b1;
        m_data = 32'h2;
        @(negedge clk);
        chk("abort_addr_odd", mem_addr, 32'h1000_0014);
        abort = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        abort = 1'b0;
        chk("abort_req_drop", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'({tlb_we, refill_done}), 32'd0);

        miss_req = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        miss_req = 1'b0;
        abort    = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_req", 32'(mem_req), 32'd0);

        miss_req   = 1'b1;
        miss_vaddr = 32'h0123_4000;
        pte_base   = 32'h2000_0000;
        @(negedge clk);
        miss_req = 1'b0;
        chk("rst_walk_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_addr", mem_addr, 32'd0);
        chk("midrst_we", 32'({tlb_we, refill_done, refill_fault}), 32'd0);
        chk("midrst_hi", tlb_entry_hi, 32'd0);
        chk("midrst_lo0", tlb_entry_lo0, 32'd0);
        chk("midrst_lo1", tlb_entry_lo1, 32'd0);
        chk("midrst_random", 32'(random_out), 32'd15);
        @(negedge clk);
        rst      = 1'b1;
        auto_mem = 1'b1;
        issue(32'h7654_2000, 32'h4000_0000, 8'hC3, 32'h3, 32'h0, 1);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("reads_empty", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
